// File: rtl/effect_mailbox_pkg.sv
// Shared definitions for the guitar_effect mailbox: RAM word map, handshake magic and the
// state encodings used by the sample feeder and its bit-banged access engine.
package effect_mailbox_pkg;

    localparam logic [4:0] AddrSe          = 5'd0;
    localparam logic [4:0] AddrGain        = 5'd1;
    localparam logic [4:0] AddrBoost       = 5'd2;
    localparam logic [4:0] AddrInput       = 5'd3;
    localparam logic [4:0] AddrReadFinish  = 5'd4;
    localparam logic [4:0] AddrOutput      = 5'd5;
    localparam logic [4:0] AddrReadyToGet  = 5'd6;

    localparam logic [31:0] ReadyMagicDefault = 32'd1100;

    typedef enum logic [3:0] {
        StIdle,
        StWrSe,
        StWrGain,
        StWrBoost,
        StWrIn,
        StWrFin,
        StPoll,
        StTimeout,
        StOutRd,
        StClrRdy,
        StClrFin,
        StEmit
    } feeder_state_e;

    typedef enum logic [1:0] {
        PhIdle,
        PhSetup,
        PhStrobe,
        PhCapture
    } access_phase_e;

    // Mailbox word touched by each access state; don't-care for the non-access states.
    function automatic logic [4:0] state_addr(input feeder_state_e st);
        logic [4:0] addr;
        addr = 5'd0;
        case (st)
            StWrSe:    addr = AddrSe;
            StWrGain:  addr = AddrGain;
            StWrBoost: addr = AddrBoost;
            StWrIn:    addr = AddrInput;
            StWrFin:   addr = AddrReadFinish;
            StPoll:    addr = AddrReadyToGet;
            StOutRd:   addr = AddrOutput;
            StClrRdy:  addr = AddrReadyToGet;
            StClrFin:  addr = AddrReadFinish;
            default:   addr = 5'd0;
        endcase
        return addr;
    endfunction

    function automatic logic is_read_state(input feeder_state_e st);
        return (st == StPoll) || (st == StOutRd);
    endfunction

endpackage

// File: rtl/mailbox_access.sv
// Bit-banged mailbox RAM port: a write is SETUP/STROBE, a read is SETUP/STROBE/CAPTURE.
// A new access may be started in the same cycle the previous one reports done.
module mailbox_access
    import effect_mailbox_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        we,
    input  logic [4:0]  addr,
    input  logic [31:0] wdata,
    output logic        done,
    output logic [31:0] rdata,
    input  logic [31:0] loc_readdata,
    output logic [31:0] loc_writedata,
    output logic [4:0]  loc_ramaddress,
    output logic        loc_ramclk,
    output logic        loc_ramread,
    output logic        loc_ramwrite
);

    access_phase_e phase_q, phase_d;
    logic [31:0]   rdata_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_q <= PhIdle;
            rdata_q <= '0;
        end else begin
            phase_q <= phase_d;
            // RAM output is valid once the strobe edge has been seen
            if (phase_q == PhStrobe && !we) begin
                rdata_q <= loc_readdata;
            end
        end
    end

    always_comb begin
        phase_d = phase_q;
        case (phase_q)
            PhIdle:    if (start) phase_d = PhSetup;
            PhSetup:   phase_d = PhStrobe;
            PhStrobe:  begin
                if (!we) begin
                    phase_d = PhCapture;
                end else begin
                    phase_d = start ? PhSetup : PhIdle;
                end
            end
            PhCapture: phase_d = start ? PhSetup : PhIdle;
            default:   phase_d = PhIdle;
        endcase
    end

    always_comb begin
        done           = ((phase_q == PhStrobe) && we) || (phase_q == PhCapture);
        rdata          = rdata_q;
        loc_ramclk     = (phase_q == PhStrobe);
        loc_ramwrite   = (phase_q == PhSetup) && we;
        loc_ramread    = ((phase_q == PhSetup) || (phase_q == PhStrobe)) && !we;
        loc_ramaddress = (phase_q != PhIdle) ? addr : 5'd0;
        loc_writedata  = ((phase_q != PhIdle) && we) ? wdata : 32'd0;
    end

endmodule

// File: rtl/effect_sample_feeder.sv
// Streams one sample at a time through the shared effect mailbox: writes settings and sample,
// polls for the core's ready flag, reads the result back, clears the handshake and emits it.
module effect_sample_feeder
    import effect_mailbox_pkg::*;
#(
    parameter logic [31:0] READY_MAGIC = ReadyMagicDefault,
    parameter int unsigned POLL_LIMIT  = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in_sample,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] effect_sel,
    input  logic [31:0] dist_gain,
    input  logic [31:0] dist_boost,
    output logic [31:0] out_sample,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        timeout_err,
    input  logic [31:0] loc_readdata,
    output logic [31:0] loc_writedata,
    output logic [4:0]  loc_ramaddress,
    output logic        loc_ramclk,
    output logic        loc_ramread,
    output logic        loc_ramwrite
);

    localparam int unsigned PollBits = $clog2(POLL_LIMIT + 1);
    localparam int unsigned CntW     = (PollBits > 11) ? PollBits : 11;

    feeder_state_e state_q, state_d;

    logic [31:0]     sample_q, se_q, gain_q, boost_q;
    logic [31:0]     result_q, result_d;
    logic [CntW-1:0] fails_q, fails_d, fails_inc;
    logic            ready_q;
    logic            err_q, err_d;
    logic            accept;

    logic            acc_start, acc_we, acc_done;
    logic [4:0]      acc_addr;
    logic [31:0]     acc_wdata, acc_rdata;

    assign accept    = in_valid && ready_q;
    assign fails_inc = (&fails_q) ? fails_q : fails_q + CntW'(1);

    // State register plus the registers the FSM loads
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
            fails_q  <= '0;
            result_q <= '0;
            sample_q <= '0;
            se_q     <= '0;
            gain_q   <= '0;
            boost_q  <= '0;
        end else begin
            state_q  <= state_d;
            // Registered so that in_ready stays low for one IDLE cycle after reset release
            ready_q  <= (state_d == StIdle);
            err_q    <= err_d;
            fails_q  <= fails_d;
            result_q <= result_d;
            if (accept) begin
                sample_q <= in_sample;
                se_q     <= effect_sel;
                gain_q   <= dist_gain;
                boost_q  <= dist_boost;
            end
        end
    end

    // Next state; acc_start launches the access belonging to state_d
    always_comb begin
        state_d   = state_q;
        acc_start = 1'b0;
        fails_d   = fails_q;
        result_d  = result_q;
        err_d     = err_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d   = StWrSe;
                    acc_start = 1'b1;
                    fails_d   = '0;
                end
            end
            StWrSe: begin
                if (acc_done) begin
                    state_d   = StWrGain;
                    acc_start = 1'b1;
                end
            end
            StWrGain: begin
                if (acc_done) begin
                    state_d   = StWrBoost;
                    acc_start = 1'b1;
                end
            end
            StWrBoost: begin
                if (acc_done) begin
                    state_d   = StWrIn;
                    acc_start = 1'b1;
                end
            end
            StWrIn: begin
                if (acc_done) begin
                    state_d   = StWrFin;
                    acc_start = 1'b1;
                end
            end
            StWrFin: begin
                if (acc_done) begin
                    state_d   = StPoll;
                    acc_start = 1'b1;
                end
            end
            StPoll: begin
                if (acc_done) begin
                    if (acc_rdata == READY_MAGIC) begin
                        state_d   = StOutRd;
                        acc_start = 1'b1;
                    end else begin
                        fails_d = fails_inc;
                        if (32'(fails_inc) < POLL_LIMIT) begin
                            state_d   = StPoll;
                            acc_start = 1'b1;
                        end else begin
                            state_d = StTimeout;
                        end
                    end
                end
            end
            StTimeout: begin
                // Dry bypass: the unprocessed sample goes out
                err_d     = 1'b1;
                result_d  = sample_q;
                state_d   = StClrRdy;
                acc_start = 1'b1;
            end
            StOutRd: begin
                if (acc_done) begin
                    result_d  = acc_rdata;
                    state_d   = StClrRdy;
                    acc_start = 1'b1;
                end
            end
            StClrRdy: begin
                if (acc_done) begin
                    state_d   = StClrFin;
                    acc_start = 1'b1;
                end
            end
            StClrFin: begin
                if (acc_done) begin
                    state_d = StEmit;
                end
            end
            StEmit: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs: access command for the current state and the stream ports
    always_comb begin
        acc_we    = !is_read_state(state_q);
        acc_addr  = state_addr(state_q);
        acc_wdata = 32'd0;
        case (state_q)
            StWrSe:    acc_wdata = se_q;
            StWrGain:  acc_wdata = gain_q;
            StWrBoost: acc_wdata = boost_q;
            StWrIn:    acc_wdata = sample_q;
            StWrFin:   acc_wdata = 32'd1;
            default:   acc_wdata = 32'd0;
        endcase
        in_ready    = ready_q;
        out_valid   = (state_q == StEmit);
        out_sample  = result_q;
        timeout_err = err_q;
    end

    mailbox_access u_access (
        .clk            (clk),
        .reset          (reset),
        .start          (acc_start),
        .we             (acc_we),
        .addr           (acc_addr),
        .wdata          (acc_wdata),
        .done           (acc_done),
        .rdata          (acc_rdata),
        .loc_readdata   (loc_readdata),
        .loc_writedata  (loc_writedata),
        .loc_ramaddress (loc_ramaddress),
        .loc_ramclk     (loc_ramclk),
        .loc_ramread    (loc_ramread),
        .loc_ramwrite   (loc_ramwrite)
    );

endmodule

// File: tb/tb_effect_sample_feeder.sv
// Bench for effect_sample_feeder: a mailbox RAM plus effect-core model answers the feeder,
// a driver pushes expected results into a queue and an output monitor checks them.
module tb_effect_sample_feeder;

    localparam int unsigned PollLimit = 8;
    localparam logic [31:0] Magic     = 32'd1100;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] in_sample = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] effect_sel = '0;
    logic [31:0] dist_gain = '0;
    logic [31:0] dist_boost = '0;
    logic [31:0] out_sample;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        timeout_err;
    logic [31:0] loc_readdata = '0;
    logic [31:0] loc_writedata;
    logic [4:0]  loc_ramaddress;
    logic        loc_ramclk;
    logic        loc_ramread;
    logic        loc_ramwrite;

    effect_sample_feeder #(
        .READY_MAGIC (Magic),
        .POLL_LIMIT  (PollLimit)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .in_sample      (in_sample),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .effect_sel     (effect_sel),
        .dist_gain      (dist_gain),
        .dist_boost     (dist_boost),
        .out_sample     (out_sample),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .timeout_err    (timeout_err),
        .loc_readdata   (loc_readdata),
        .loc_writedata  (loc_writedata),
        .loc_ramaddress (loc_ramaddress),
        .loc_ramclk     (loc_ramclk),
        .loc_ramread    (loc_ramread),
        .loc_ramwrite   (loc_ramwrite)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] sample;
        logic [31:0] se;
        logic [31:0] gain;
        logic [31:0] boost;
        logic [31:0] result;
        bit          timeout;
        int          acc_cyc;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int   delay_q[$];
    int   vectors = 0;
    int   errors = 0;
    int   cyc = 0;
    int   or_mode = 0;  // 0: always ready, 1: random, 2: stall 10 cycles

    always @(posedge clk) cyc++;

    // What the effect core does to a sample
    function automatic logic [31:0] effect_fn(input logic [31:0] s, input logic [31:0] se,
                                              input logic [31:0] g, input logic [31:0] b);
        return ((s ^ se) + (g * 32'd3)) ^ {b[15:0], b[31:16]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, req);
        end
    endtask

    // Mailbox RAM with the effect core behind it
    logic [31:0] mem [32];
    bit          pend;
    logic [4:0]  pend_addr;
    logic [31:0] pend_data;
    bit          fin;
    int          polls;
    int          cur_delay;

    always @(negedge clk) begin
        if (!reset) begin
            pend = 0;
            fin = 0;
            polls = 0;
            cur_delay = 0;
            loc_readdata = '0;
            for (int i = 0; i < 32; i++) mem[i] = '0;
        end else begin
            if (loc_ramread && loc_ramwrite) begin
                errors++;
                $display("FAIL strobe_excl: read=%0b write=%0b, want not both", loc_ramread,
                         loc_ramwrite);
            end
            if (loc_ramwrite) begin
                pend = 1;
                pend_addr = loc_ramaddress;
                pend_data = loc_writedata;
            end else if (loc_ramclk && pend) begin
                pend = 0;
                mem[pend_addr] = pend_data;
                if (pend_addr == 5'd4 && pend_data == 32'd1) begin
                    fin = 1;
                    polls = 0;
                    cur_delay = (delay_q.size() > 0) ? delay_q.pop_front() : 0;
                    mem[5] = effect_fn(mem[3], mem[0], mem[1], mem[2]);
                end else if (pend_addr == 5'd4) begin
                    fin = 0;
                end
            end
            if (loc_ramclk && loc_ramread) begin
                if (loc_ramaddress == 5'd6 && fin) begin
                    if (polls >= cur_delay) mem[6] = Magic;
                    polls++;
                end
                loc_readdata = mem[loc_ramaddress];
            end
        end
    end

    // Output monitor / scoreboard
    logic [31:0] held;
    bit          prev_ov;
    int          stall_cnt;
    bit          exp_err;

    always @(negedge clk) begin
        if (!reset) begin
            out_ready = 1'b0;
            prev_ov = 0;
            stall_cnt = 0;
            exp_err = 0;
        end else begin
            case (or_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = out_valid && (stall_cnt >= 10);
            endcase
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got 0x%08h, want no output", out_sample);
                end else if (!prev_ov) begin
                    held = out_sample;
                    if (exp_q[0].lat >= 0)
                        check("latency", 32'(cyc - exp_q[0].acc_cyc), 32'(exp_q[0].lat));
                end else begin
                    check("hold_sample", out_sample, held);
                    check("hold_in_ready", {31'd0, in_ready}, 32'd0);
                    check("hold_no_strobe", {29'd0, loc_ramclk, loc_ramread, loc_ramwrite},
                          32'd0);
                end
                if (out_ready && exp_q.size() > 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (e.timeout) exp_err = 1;
                    check("out_sample", out_sample, e.result);
                    check("timeout_err", {31'd0, timeout_err}, {31'd0, exp_err});
                    check("mem_se", mem[0], e.se);
                    check("mem_gain", mem[1], e.gain);
                    check("mem_boost", mem[2], e.boost);
                    check("mem_input", mem[3], e.sample);
                    check("mem_fin_clr", mem[4], 32'd0);
                    check("mem_rdy_clr", mem[6], 32'd0);
                    stall_cnt = 0;
                end else begin
                    stall_cnt++;
                end
            end
            prev_ov = out_valid && !out_ready;
        end
    end

    task automatic send(input logic [31:0] s, input int delay, output int acc);
        int   waited;
        exp_t e;
        waited = 0;
        acc = -1;
        @(negedge clk);
        in_sample  = s;
        effect_sel = $urandom;
        dist_gain  = $urandom;
        dist_boost = $urandom;
        in_valid   = 1'b1;
        while (!in_ready && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            errors++;
            $display("FAIL accept_wait: in_ready=0 after %0d cycles, want 1", waited);
            in_valid = 1'b0;
            return;
        end
        e.sample  = s;
        e.se      = effect_sel;
        e.gain    = dist_gain;
        e.boost   = dist_boost;
        e.timeout = (delay >= int'(PollLimit));
        e.result  = e.timeout ? s : effect_fn(s, effect_sel, dist_gain, dist_boost);
        e.acc_cyc = cyc;
        e.lat     = e.timeout ? -1 : 21 + 3 * delay;
        exp_q.push_back(e);
        delay_q.push_back(delay);
        acc = cyc;
        @(posedge clk);
        #1;
        // Settings wander after the accept; the feeder must keep what it latched
        in_valid   = 1'b0;
        in_sample  = $urandom;
        effect_sel = $urandom;
        dist_gain  = $urandom;
        dist_boost = $urandom;
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while (exp_q.size() > 0 && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d outputs outstanding, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_out_sample"}, out_sample, 32'd0);
        check({tag, "_timeout_err"}, {31'd0, timeout_err}, 32'd0);
        check({tag, "_strobes"}, {29'd0, loc_ramclk, loc_ramread, loc_ramwrite}, 32'd0);
        check({tag, "_addr_data"}, loc_writedata | {27'd0, loc_ramaddress}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, want finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a0, a1, a2;
        int waited;
        // Reset values and the single IDLE cycle after release
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("release_idle", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        check("release_ready", {31'd0, in_ready}, 32'd1);

        // Single sample, best case, then four failed polls, then timeout
        or_mode = 0;
        send(32'h0000_1234, 0, a0);
        drain();
        send(32'h0000_1234, 4, a0);
        drain();
        send(32'h0BAD_CAFE, 1000, a0);
        drain();

        // Output stalled in EMIT
        or_mode = 2;
        send($urandom, 2, a0);
        drain();

        // Back-to-back stream
        or_mode = 0;
        send($urandom, 0, a0);
        send($urandom, 0, a1);
        send($urandom, 0, a2);
        check("spacing_1", 32'(a1 - a0), 32'd22);
        check("spacing_2", 32'(a2 - a1), 32'd22);
        drain();

        // Random samples, poll delays and backpressure
        or_mode = 1;
        for (int i = 0; i < 16; i++) send($urandom, int'($urandom_range(0, 10)), a0);
        drain();

        // Reset during the WR_IN strobe
        or_mode = 0;
        send(32'h5555_AAAA, 0, a0);
        waited = 0;
        while (!(loc_ramclk && !loc_ramread && loc_ramaddress == 5'd3) && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check("wr_in_strobe_seen", {31'd0, loc_ramclk}, 32'd1);
        #2 reset = 1'b0;
        exp_q.delete();
        delay_q.delete();
        #1;
        check_reset_outputs("midreset");
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("midreset_idle", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        check("midreset_ready", {31'd0, in_ready}, 32'd1);

        // Recovery after reset
        send($urandom, 1, a0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/effect_sample_feeder.md
# effect_sample_feeder

Upstream stage of `guitar_effect`: accepts one 32-bit audio sample at a time on a valid/ready stream, writes it and the current effect settings into the shared 32×32 mailbox RAM, and waits for the effect core to flag completion. It then reads back the processed sample, clears the handshake words, and presents the result on an output stream. It drives the mailbox RAM through the same bit-banged port (`loc_ramclk` toggled by logic) that the effect core uses.

## Interface
- `READY_MAGIC`, 32'd1100, value the effect core writes to READY_TO_GET when the output is valid
- `POLL_LIMIT`, 1024, failed polls before timeout (≥1)
- `clk` in 1: single system clock
- `reset` in 1: asynchronous, active-low reset
- `in_sample` in 32: sample to process
- `in_valid` in 1 / `in_ready` out 1: input handshake, transfer when both high on a `clk` edge
- `effect_sel` in 32, `dist_gain` in 32, `dist_boost` in 32: settings, latched with each accepted sample
- `out_sample` out 32 / `out_valid` out 1 / `out_ready` in 1: output handshake
- `timeout_err` out 1: sticky, set on poll timeout, cleared only by reset
- `loc_readdata` in 32: mailbox read data
- `loc_writedata` out 32, `loc_ramaddress` out 5, `loc_ramclk` out 1, `loc_ramread` out 1, `loc_ramwrite` out 1: mailbox port

## Operation
- Mailbox map: SE=0, GAIN=1, BOOST=2, INPUT=3, READ_FINISH=4, OUTPUT=5, READY_TO_GET=6.
- Write access, 2 cycles: SETUP (addr/data valid, `loc_ramwrite`=1, `loc_ramclk`=0), STROBE (`loc_ramclk`=1, `loc_ramwrite`=0).
- Read access, 3 cycles: SETUP (`loc_ramread`=1, `loc_ramclk`=0), STROBE (`loc_ramclk`=1), CAPTURE (`loc_ramread`=0, `loc_ramclk`=0, `loc_readdata` registered).
- FSM: IDLE → WR_SE → WR_GAIN → WR_BOOST → WR_IN → WR_FIN (data 1) → POLL → {OUT_RD if readdata==READY_MAGIC; POLL again if not and fail count < POLL_LIMIT; TIMEOUT otherwise} → CLR_RDY (data 0 to addr 6) → CLR_FIN (data 0 to addr 4) → EMIT → IDLE.
- IDLE: `in_ready`=1; on transfer, latch sample and three settings, clear poll counter.
- TIMEOUT: set `timeout_err`; result = latched input sample (dry bypass); continue to CLR_RDY.
- EMIT: `out_valid`=1, `out_sample` held stable until `out_ready`; `in_ready`=0 throughout, so no new sample is accepted until EMIT completes.
- Poll counter: 11 bits minimum, saturating; compare is exact 32-bit equality.
- Settings inputs change mid-operation: ignored until the next accept.

## Timing
- Reset values: all outputs 0 (`in_ready`=0, `out_valid`=0, `loc_ramclk`=0, strobes 0, `timeout_err`=0); state IDLE; `in_ready` rises on the first edge after reset release.
- Accept at cycle 0. Writes occupy cycles 1–10. First poll occupies 11–13 with compare at 13. OUTPUT read occupies 14–16. Clears occupy 17–20. `out_valid` is high from cycle 21.
- Best-case accept-to-`out_valid` latency is 21 cycles. Each extra failed poll adds 3 cycles.
- EMIT with `out_ready` already high: transfer at cycle 21, IDLE (`in_ready`=1) at cycle 22.
- Reset asserted mid-access: outputs go to reset values immediately, no cleanup writes are issued, and mailbox contents are undefined.
- Only one of `loc_ramread`/`loc_ramwrite` is ever high. Strobes change only while `loc_ramclk`=0.

## Structure
- `effect_mailbox_pkg`: mailbox address constants, `READY_MAGIC` default, FSM state enum. The package is shared with `guitar_effect`.
- Sub-module `mailbox_access`: 2/3-cycle access engine with req/we/addr/wdata in and done/rdata out. The top FSM sequences it.

## Test plan
- Single sample 0x0000_1234, RAM model sets addr6=1100 after READ_FINISH=1 and puts 0x0000_5678 at addr5 → `out_sample`=0x5678 at cycle 21. Addr4 and addr6 read back 0. Addrs 0–3 hold the latched settings and sample.
- Model delays 1100 by 4 polls → `out_valid` 12 cycles later than the single-sample case, same data.
- Model never writes 1100, `POLL_LIMIT`=4 → `timeout_err`=1, `out_sample` equals input, clears still issued.
- `out_ready` held low for 10 cycles in EMIT → `out_sample` is stable, `in_ready`=0, no RAM strobes occur.
- Back-to-back stream of 3 samples with `out_ready`=1 → 3 outputs in order, 22-cycle spacing.
- Reset pulsed during WR_IN STROBE → all outputs 0 in the same cycle. After release, one IDLE cycle occurs and then `in_ready`=1.
